boot_loader: RTL

- Writer-side counterpart to the instruction-fetch control path: fills program memory from a byte stream while holding the CPU in reset.
- Releases the CPU once a complete, checksum-verified image has been written.
- Sits between the host byte receiver (UART RX or equivalent) and port A of program memory; its cpu_reset output drives the control FSM and PC reset.

---
 rtl/boot_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Byte-stream program loader: fills program memory from a framed, XOR-checksummed
// image while holding the CPU in reset, then releases it on a verified image.
module boot_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 1024,
  parameter int                    TIMEOUT    = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  input  logic                  i_restart,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_data,
  output logic                  o_mem_w_en,
  output logic                  o_cpu_reset,
  output logic                  o_load_done,
  output logic                  o_load_error,
  output logic [15:0]           o_words_loaded
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_LO  = 4'd1;
  localparam logic [3:0] S_DATA_HI = 4'd2;
  localparam logic [3:0] S_DATA_LO = 4'd3;
  localparam logic [3:0] S_WRITE   = 4'd4;
  localparam logic [3:0] S_CHK_HI  = 4'd5;
  localparam logic [3:0] S_CHK_LO  = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;

  localparam logic [31:0] MAX_W    = 32'(MAX_WORDS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  logic [3:0]            r_state;
  logic [15:0]           r_len;
  logic [7:0]            r_hi;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [15:0]           r_checksum;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [15:0]           r_mem_data;
  logic [15:0]           r_words_loaded;
  logic [31:0]           r_tmo;

  logic        w_accept;
  logic        w_waiting;
  logic        w_expire;
  logic        w_last;
  logic [15:0] w_word;
  logic [15:0] w_len_full;

  assign o_rx_ready = (r_state == S_IDLE)    || (r_state == S_LEN_LO) ||
                      (r_state == S_DATA_HI) || (r_state == S_DATA_LO) ||
                      (r_state == S_CHK_HI)  || (r_state == S_CHK_LO);

  assign w_accept   = i_rx_valid && o_rx_ready;
  assign w_waiting  = o_rx_ready && (r_state != S_IDLE);
  // A byte landing on the expiry edge takes priority over the timeout.
  assign w_expire   = w_waiting && !w_accept && (r_tmo == TMO_LAST);
  assign w_last     = (32'(r_index) + 32'd1) == {16'd0, r_len};
  assign w_word     = {r_hi, i_rx_data};
  assign w_len_full = {r_len[15:8], i_rx_data};

  assign o_mem_addr     = r_mem_addr;
  assign o_mem_data     = r_mem_data;
  assign o_mem_w_en     = (r_state == S_WRITE);
  assign o_cpu_reset    = (r_state != S_DONE);
  assign o_load_done    = (r_state == S_DONE);
  assign o_load_error   = (r_state == S_ERROR);
  assign o_words_loaded = r_words_loaded;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_hi           <= '0;
      r_index        <= '0;
      r_checksum     <= '0;
      r_mem_addr     <= BASE_ADDR;
      r_mem_data     <= '0;
      r_words_loaded <= '0;
      r_tmo          <= '0;
    end else begin
      if (w_accept || !w_waiting || w_expire) r_tmo <= '0;
      else                                    r_tmo <= r_tmo + 32'd1;

      if (w_expire) begin
        r_state <= S_ERROR;
      end else begin
        case (r_state)
          S_IDLE: if (w_accept) begin
            r_len   <= {i_rx_data, 8'h00};
            r_state <= S_LEN_LO;
          end
          S_LEN_LO: if (w_accept) begin
            r_len[7:0] <= i_rx_data;
            if ({16'd0, w_len_full} > MAX_W) r_state <= S_ERROR;
            else if (w_len_full == 16'd0)    r_state <= S_CHK_HI;
            else                             r_state <= S_DATA_HI;
          end
          S_DATA_HI: if (w_accept) begin
            r_hi    <= i_rx_data;
            r_state <= S_DATA_LO;
          end
          // Address and data are captured here so they hold after the strobe.
          S_DATA_LO: if (w_accept) begin
            r_mem_data <= w_word;
            r_mem_addr <= BASE_ADDR + r_index;
            r_state    <= S_WRITE;
          end
          S_WRITE: begin
            r_checksum     <= r_checksum ^ r_mem_data;
            r_index        <= r_index + ADDR_WIDTH'(1);
            r_words_loaded <= r_words_loaded + 16'd1;
            r_state        <= w_last ? S_CHK_HI : S_DATA_HI;
          end
          S_CHK_HI: if (w_accept) begin
            r_hi    <= i_rx_data;
            r_state <= S_CHK_LO;
          end
          S_CHK_LO: if (w_accept) begin
            r_state <= (w_word == r_checksum) ? S_DONE : S_ERROR;
          end
          S_DONE, S_ERROR: if (i_restart) begin
            r_state        <= S_IDLE;
            r_len          <= '0;
            r_hi           <= '0;
            r_index        <= '0;
            r_checksum     <= '0;
            r_words_loaded <= '0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
